// File: rtl/pwm_multi_channel.sv
// NUM_CH independent PWM channels behind one Wishbone slave, sharing one prescaler.
// Period/duty are shadowed per channel; sticky wrap flags feed a single level interrupt.
module pwm_multi_channel #(
    parameter int NUM_CH = 4,
    parameter int DW     = 16,
    parameter int AW     = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_wb_cyc,
    input  logic              i_wb_stb,
    input  logic              i_wb_we,
    input  logic [AW-1:0]     i_wb_adr,
    input  logic [DW-1:0]     i_wb_data,
    output logic [DW-1:0]     o_wb_data,
    output logic              o_wb_ack,
    output logic [NUM_CH-1:0] o_pwm,
    output logic              o_irq
);
    // channel n occupies word addresses 0x10+4n .. 0x13+4n
    localparam logic [AW-3:0] CH_BASE = (AW-2)'(4);

    logic              req;
    logic              wr;
    logic [AW-3:0]     ch_idx;
    logic [1:0]        ch_reg;
    logic              in_ch;
    logic [NUM_CH-1:0] ch_hit;
    logic [NUM_CH-1:0] wr_ctrl;
    logic [NUM_CH-1:0] wr_per;
    logic [NUM_CH-1:0] wr_duty;
    logic [NUM_CH-1:0] wr_stat;
    logic              wr_gctrl;
    logic              wr_div;
    logic              sync;
    logic [DW-1:0]     rd_mux;

    logic              gen;
    logic [DW-1:0]     div;
    logic [DW-1:0]     pcnt;
    logic              tick;

    logic [NUM_CH-1:0] en;
    logic [NUM_CH-1:0] center;
    logic [NUM_CH-1:0] inv;
    logic [NUM_CH-1:0] irq_en;
    logic [NUM_CH-1:0] down;
    logic [NUM_CH-1:0] flag;
    logic [NUM_CH-1:0] pwm_q;
    logic [NUM_CH-1:0] active;
    logic [NUM_CH-1:0] wrap;
    logic [NUM_CH-1:0] raw;
    logic [DW-1:0]     per_stage [NUM_CH];
    logic [DW-1:0]     duty_stage[NUM_CH];
    logic [DW-1:0]     per_act   [NUM_CH];
    logic [DW-1:0]     duty_act  [NUM_CH];
    logic [DW-1:0]     cnt       [NUM_CH];

    assign req      = i_wb_cyc & i_wb_stb & ~o_wb_ack;
    assign wr       = req & i_wb_we;
    assign ch_reg   = i_wb_adr[1:0];
    assign ch_idx   = i_wb_adr[AW-1:2] - CH_BASE;
    assign in_ch    = (i_wb_adr[AW-1:2] >= CH_BASE) && (ch_idx < (AW-2)'(NUM_CH));
    assign wr_gctrl = wr && (i_wb_adr == AW'(0));
    assign wr_div   = wr && (i_wb_adr == AW'(1));
    assign sync     = wr_gctrl & i_wb_data[1];

    always_comb begin
        for (int n = 0; n < NUM_CH; n++) begin
            ch_hit[n]  = in_ch && (ch_idx == (AW-2)'(n));
            wr_ctrl[n] = wr && ch_hit[n] && (ch_reg == 2'd0);
            wr_per[n]  = wr && ch_hit[n] && (ch_reg == 2'd1);
            wr_duty[n] = wr && ch_hit[n] && (ch_reg == 2'd2);
            wr_stat[n] = wr && ch_hit[n] && (ch_reg == 2'd3);
        end
    end

    always_comb begin
        rd_mux = '0;
        if (i_wb_adr == AW'(0)) begin
            rd_mux[0] = gen;
        end else if (i_wb_adr == AW'(1)) begin
            rd_mux = div;
        end else begin
            for (int n = 0; n < NUM_CH; n++) begin
                if (ch_hit[n]) begin
                    case (ch_reg)
                        2'd0:    rd_mux[3:0] = {irq_en[n], inv[n], center[n], en[n]};
                        2'd1:    rd_mux      = per_stage[n];
                        2'd2:    rd_mux      = duty_stage[n];
                        default: rd_mux[0]   = flag[n];
                    endcase
                end
            end
        end
    end

    // ack is never issued back-to-back, so a strobe held through ack is ignored
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_wb_ack  <= 1'b0;
            o_wb_data <= '0;
        end else begin
            o_wb_ack  <= req;
            o_wb_data <= (req && !i_wb_we) ? rd_mux : '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            gen <= 1'b0;
            div <= '0;
        end else begin
            if (wr_gctrl) gen <= i_wb_data[0];
            if (wr_div)   div <= i_wb_data;
        end
    end

    assign tick = gen && (pcnt == div);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)    pcnt <= '0;
        else if (!gen)   pcnt <= '0;
        else if (tick)   pcnt <= '0;
        else             pcnt <= pcnt + DW'(1);
    end

    always_comb begin
        for (int n = 0; n < NUM_CH; n++) begin
            active[n] = gen & en[n];
            raw[n]    = (per_act[n] != '0) && (cnt[n] < duty_act[n]);
            if (center[n])
                wrap[n] = active[n] && tick && (per_act[n] != '0) && down[n] && (cnt[n] == '0);
            else
                wrap[n] = active[n] && tick && (per_act[n] != '0) && (cnt[n] == per_act[n] - DW'(1));
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            en     <= '0;
            center <= '0;
            inv    <= '0;
            irq_en <= '0;
            for (int n = 0; n < NUM_CH; n++) begin
                per_stage[n]  <= '0;
                duty_stage[n] <= '0;
            end
        end else begin
            for (int n = 0; n < NUM_CH; n++) begin
                if (wr_ctrl[n]) begin
                    en[n]     <= i_wb_data[0];
                    center[n] <= i_wb_data[1];
                    inv[n]    <= i_wb_data[2];
                    irq_en[n] <= i_wb_data[3];
                end
                if (wr_per[n])  per_stage[n]  <= i_wb_data;
                if (wr_duty[n]) duty_stage[n] <= i_wb_data;
            end
        end
    end

    // center mode dwells twice on P-1 and on 0, giving a 2P-tick symmetric period
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            down  <= '0;
            flag  <= '0;
            pwm_q <= '0;
            for (int n = 0; n < NUM_CH; n++) begin
                cnt[n]      <= '0;
                per_act[n]  <= '0;
                duty_act[n] <= '0;
            end
        end else begin
            for (int n = 0; n < NUM_CH; n++) begin
                if (!active[n] || sync) begin
                    cnt[n]  <= '0;
                    down[n] <= 1'b0;
                end else if (tick && (per_act[n] != '0)) begin
                    if (!center[n]) begin
                        cnt[n] <= wrap[n] ? '0 : cnt[n] + DW'(1);
                    end else if (!down[n]) begin
                        if (cnt[n] == per_act[n] - DW'(1)) down[n] <= 1'b1;
                        else                               cnt[n]  <= cnt[n] + DW'(1);
                    end else begin
                        if (cnt[n] == '0) down[n] <= 1'b0;
                        else              cnt[n]  <= cnt[n] - DW'(1);
                    end
                end
                if (!active[n] || wrap[n] || sync) begin
                    per_act[n]  <= per_stage[n];
                    duty_act[n] <= duty_stage[n];
                end
                if (wrap[n])                        flag[n] <= 1'b1;
                else if (wr_stat[n] && i_wb_data[0]) flag[n] <= 1'b0;
                pwm_q[n] <= active[n] ? (raw[n] ^ inv[n]) : inv[n];
            end
        end
    end

    assign o_pwm = pwm_q;
    assign o_irq = |(flag & irq_en);

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Randomized bench for pwm_multi_channel: a per-cycle phase-based reference model
// pushes expected outputs into a queue that a negedge monitor pops and compares.
module tb_pwm_multi_channel;
    localparam int NCH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [7:0]  adr = '0;
    logic [15:0] wdat = '0;
    logic [15:0] rdat;
    logic        ack;
    logic [3:0]  pwm;
    logic        irq;

    int n_checks = 0;
    int n_err = 0;

    pwm_multi_channel #(.NUM_CH(NCH), .DW(16), .AW(8)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we),
        .i_wb_adr(adr), .i_wb_data(wdat), .o_wb_data(rdat), .o_wb_ack(ack),
        .o_pwm(pwm), .o_irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  pwm;
        logic        irq;
        logic        ack;
        bit          rd;
        logic [15:0] data;
    } exp_t;
    exp_t q[$];

    // reference model: phase = ticks elapsed in the current period
    bit m_gen, m_ack;
    int m_div, m_pcnt;
    bit m_en[NCH], m_cen[NCH], m_inv[NCH], m_ie[NCH], m_flag[NCH];
    int m_stp[NCH], m_std[NCH], m_ap[NCH], m_ad[NCH], m_ph[NCH];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_gen = 0; m_ack = 0; m_div = 0; m_pcnt = 0;
        for (int n = 0; n < NCH; n++) begin
            m_en[n] = 0; m_cen[n] = 0; m_inv[n] = 0; m_ie[n] = 0; m_flag[n] = 0;
            m_stp[n] = 0; m_std[n] = 0; m_ap[n] = 0; m_ad[n] = 0; m_ph[n] = 0;
        end
    endtask

    function automatic bit model_raw(int n);
        int p, v;
        p = m_ap[n];
        if (p == 0) return 1'b0;
        if (m_cen[n]) v = (m_ph[n] < p) ? m_ph[n] : 2 * p - 1 - m_ph[n];
        else          v = m_ph[n];
        return v < m_ad[n];
    endfunction

    function automatic int model_read(int a);
        int n, r;
        if (a == 0) return int'(m_gen);
        if (a == 1) return m_div;
        if (a >= 16 && a < 16 + 4 * NCH) begin
            n = (a - 16) / 4;
            r = a % 4;
            case (r)
                0:       return int'(m_en[n]) + 2 * int'(m_cen[n]) + 4 * int'(m_inv[n]) + 8 * int'(m_ie[n]);
                1:       return m_stp[n];
                2:       return m_std[n];
                default: return int'(m_flag[n]);
            endcase
        end
        return 0;
    endfunction

    task automatic model_step();
        exp_t e;
        bit req, tick, sync, act, wrap, clr;
        int a, d, len;
        req  = cyc && stb && !m_ack;
        a    = int'(adr);
        d    = int'(wdat);
        e.ack  = req;
        e.rd   = req && !we;
        e.data = e.rd ? 16'(model_read(a)) : 16'h0;
        for (int n = 0; n < NCH; n++)
            e.pwm[n] = (m_gen && m_en[n]) ? (model_raw(n) ^ m_inv[n]) : m_inv[n];
        tick = m_gen && (m_pcnt == m_div);
        sync = req && we && (a == 0) && wdat[1];
        for (int n = 0; n < NCH; n++) begin
            act  = m_gen && m_en[n];
            len  = m_cen[n] ? 2 * m_ap[n] : m_ap[n];
            wrap = act && tick && (m_ap[n] != 0) && (m_ph[n] == len - 1);
            if (!act) m_ph[n] = 0;
            else if (tick && m_ap[n] != 0) m_ph[n] = wrap ? 0 : m_ph[n] + 1;
            if (sync) m_ph[n] = 0;
            if (!act || wrap || sync) begin
                m_ap[n] = m_stp[n];
                m_ad[n] = m_std[n];
            end
            clr = req && we && (a == 19 + 4 * n) && wdat[0];
            if (wrap) m_flag[n] = 1;
            else if (clr) m_flag[n] = 0;
        end
        if (!m_gen || tick) m_pcnt = 0;
        else m_pcnt = m_pcnt + 1;
        if (req && we) begin
            if (a == 0) m_gen = wdat[0];
            else if (a == 1) m_div = d;
            else if (a >= 16 && a < 16 + 4 * NCH) begin
                case (a % 4)
                    0: begin
                        m_en[(a-16)/4] = wdat[0]; m_cen[(a-16)/4] = wdat[1];
                        m_inv[(a-16)/4] = wdat[2]; m_ie[(a-16)/4] = wdat[3];
                    end
                    1: m_stp[(a-16)/4] = d;
                    2: m_std[(a-16)/4] = d;
                    default: ;
                endcase
            end
        end
        m_ack = req;
        e.irq = 0;
        for (int n = 0; n < NCH; n++) e.irq = e.irq | (m_flag[n] & m_ie[n]);
        q.push_back(e);
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset();
                q.delete();
            end else begin
                model_step();
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && q.size() > 0) begin
                e = q.pop_front();
                chk("pwm", 32'(pwm), 32'(e.pwm));
                chk("irq", 32'(irq), 32'(e.irq));
                chk("ack", 32'(ack), 32'(e.ack));
                if (e.rd) chk("rdata", 32'(rdat), 32'(e.data));
            end
        end
    end

    task automatic wb_write(input int a, input int d);
        cyc = 1; stb = 1; we = 1; adr = 8'(a); wdat = 16'(d);
        @(negedge clk);
        cyc = 0; stb = 0; we = 0;
        @(negedge clk);
    endtask

    task automatic wb_read(input int a);
        cyc = 1; stb = 1; we = 0; adr = 8'(a);
        @(negedge clk);
        cyc = 0; stb = 0;
        @(negedge clk);
    endtask

    task automatic count_high(input int ch, input int ncyc, output int hi);
        hi = 0;
        repeat (ncyc) begin
            @(negedge clk);
            hi += int'(pwm[ch]);
        end
    endtask

    initial begin
        int hi, n, op, v;
        bit cen[NCH];

        #1;
        chk("reset_pwm", 32'(pwm), 0);
        chk("reset_ack", 32'(ack), 0);
        chk("reset_irq", 32'(irq), 0);
        chk("reset_rdata", 32'(rdat), 0);
        repeat (3) @(negedge clk);
        rst_n = 1;
        @(negedge clk);

        // bus basics, including a strobe held through ack
        wb_read(8'h00); wb_read(8'h10); wb_read(8'h13);
        wb_write(8'h01, 3);
        wb_read(8'h01);
        cyc = 1; stb = 1; we = 0; adr = 8'h01;
        repeat (3) @(negedge clk);
        cyc = 0; stb = 0;
        @(negedge clk);

        // edge PWM on ch0
        wb_write(8'h01, 0);
        wb_write(8'h11, 10);
        wb_write(8'h12, 3);
        wb_write(8'h10, 1);
        wb_write(8'h00, 1);
        repeat (15) @(negedge clk);
        count_high(0, 20, hi);
        chk("edge_d3_high", hi, 6);
        wb_write(8'h12, 0);
        repeat (12) @(negedge clk);
        count_high(0, 20, hi);
        chk("edge_d0_high", hi, 0);
        wb_write(8'h12, 12);
        repeat (12) @(negedge clk);
        count_high(0, 20, hi);
        chk("edge_d12_high", hi, 20);

        // shadow update mid-period
        wb_write(8'h12, 3);
        repeat (23) @(negedge clk);
        wb_write(8'h12, 7);
        repeat (30) @(negedge clk);

        // center mode with prescaler on ch1
        wb_write(8'h00, 0);
        wb_write(8'h01, 1);
        wb_write(8'h15, 4);
        wb_write(8'h16, 2);
        wb_write(8'h14, 3);
        wb_write(8'h00, 1);
        repeat (40) @(negedge clk);
        count_high(1, 32, hi);
        chk("center_high", hi, 16);

        // IRQ on ch0 with a short period so W1C collides with a wrap
        wb_write(8'h00, 0);
        wb_write(8'h01, 0);
        wb_write(8'h11, 2);
        wb_write(8'h10, 9);
        wb_write(8'h00, 1);
        repeat (6) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            wb_write(8'h13, 1);
            repeat (i) @(negedge clk);
        end
        repeat (4) @(negedge clk);
        wb_write(8'h10, 8);
        chk("irq_before_clear", 32'(irq), 1);
        wb_write(8'h13, 1);
        chk("irq_after_clear", 32'(irq), 0);

        // multi-channel, SYNC, INV
        wb_write(8'h11, 10); wb_write(8'h12, 3); wb_write(8'h10, 1);
        wb_write(8'h15, 6);  wb_write(8'h16, 2); wb_write(8'h14, 3);
        wb_write(8'h19, 7);  wb_write(8'h1A, 4); wb_write(8'h18, 5);
        wb_write(8'h1D, 5);  wb_write(8'h1E, 5); wb_write(8'h1C, 1);
        repeat (23) @(negedge clk);
        wb_write(8'h00, 3);
        repeat (30) @(negedge clk);
        wb_write(8'h18, 4);
        chk("inv_idle", 32'(pwm[2]), 1);

        // randomized traffic; CENTER only changes while a channel is disabled
        for (int c = 0; c < NCH; c++) begin
            cen[c] = 1'($urandom_range(0, 1));
            wb_write(16 + 4 * c, 2 * int'(cen[c]));
        end
        for (int it = 0; it < 120; it++) begin
            n  = $urandom_range(0, NCH - 1);
            op = $urandom_range(0, 9);
            case (op)
                0, 1: begin
                    v = (($urandom_range(0, 3) != 0) ? 1 : 0) + 2 * int'(cen[n])
                        + 4 * $urandom_range(0, 1) + 8 * $urandom_range(0, 1);
                    wb_write(16 + 4 * n, v);
                end
                2: wb_write(17 + 4 * n, $urandom_range(0, 12));
                3: wb_write(18 + 4 * n, $urandom_range(0, 14));
                4: wb_write(19 + 4 * n, $urandom_range(0, 1));
                5: wb_read($urandom_range(0, 47));
                6: wb_write(0, 1 + 2 * $urandom_range(0, 1));
                7: begin
                    wb_write(0, 0);
                    wb_write(1, $urandom_range(0, 3));
                    wb_write(0, 1);
                end
                8: wb_read(16 + 4 * n + $urandom_range(0, 3));
                default: wb_write(0, $urandom_range(0, 1));
            endcase
            repeat ($urandom_range(0, 6)) @(negedge clk);
        end

        // asynchronous reset while an output is high
        wb_write(8'h10, 4);
        chk("pre_reset_pwm0", 32'(pwm[0]), 1);
        #2 rst_n = 0;
        #1 chk("async_reset_pwm", 32'(pwm), 0);
        chk("async_reset_irq", 32'(irq), 0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        wb_read(8'h10);
        wb_read(8'h01);
        repeat (4) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
